rv_sram_ctrl: RTL and testbench

- Bridges the SoC's 32-bit word data bus to the board's 1M x 16 asynchronous SRAM; sits directly between the core/interconnect and the SRAM pins.
- Each 32-bit access becomes a low-half then a high-half 16-bit SRAM cycle, timed by a programmable wait counter.
- All SRAM control outputs are registered (glitch-free). Upper-level top tristates SRAM_DQ from sram_we_n.

---
 rtl/rv_pkg.sv | 18 +
 rtl/rv_sram_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_rv_sram_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/rv_pkg.sv
// Shared RV SoC definitions: data width and SRAM bridge types.
package rv_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned SRAM_AW_DEF = 20;

    // SRAM bridge FSM; write states are qualified by a separate half flag
    typedef enum logic [2:0] {
        StIdle,
        StRdLo,
        StRdHi,
        StWrSetup,
        StWrPulse,
        StWrHold,
        StDone
    } sram_state_t;

endpackage

// File: rtl/rv_sram_ctrl.sv
// 32-bit word bus to 16-bit asynchronous SRAM bridge.
// Each word access is split into a low-half then a high-half SRAM cycle.
// All SRAM strobes, address and write data are driven straight from flops.
// Build option: RV_SRAM_SKIP_HALF_EN skips write halves with no byte enables.
module rv_sram_ctrl
    import rv_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned SRAM_AW     = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               arstn_i,
    input  logic               req_i,
    output logic               ready_o,
    input  logic               we_i,
    input  logic [XLEN-1:0]    addr_i,
    input  logic [31:0]        wdata_i,
    input  logic [3:0]         be_i,
    output logic               rvalid_o,
    output logic [31:0]        rdata_o,
    output logic [SRAM_AW-1:0] sram_addr,
    input  logic [15:0]        sram_data_i,
    output logic [15:0]        sram_data_o,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int unsigned   CW      = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CntLoad = CW'(WAIT_CYCLES - 1);

    sram_state_t   state_q;
    logic          half_q;
    logic [CW-1:0] cnt_q;
    logic [18:0]   idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic [15:0]   rd_lo_q;
    logic          hi_run;
    logic          unused_addr;

    // Only the word index of the byte address reaches the SRAM
    assign unused_addr = ^{addr_i[XLEN-1:21], addr_i[1:0]};

    assign ready_o = (state_q == StIdle);

    // Whether the high write half runs after the low half
`ifdef RV_SRAM_SKIP_HALF_EN
    assign hi_run = |be_q[3:2];
`else
    assign hi_run = 1'b1;
`endif

    // Access sequencer with registered SRAM strobes and completion outputs
    always_ff @(posedge clk or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= StIdle;
            half_q      <= 1'b0;
            cnt_q       <= CntLoad;
            idx_q       <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            rd_lo_q     <= '0;
            rvalid_o    <= 1'b0;
            rdata_o     <= '0;
            sram_addr   <= '0;
            sram_data_o <= '0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    rvalid_o <= 1'b0;
                    if (req_i) begin
                        idx_q   <= addr_i[20:2];
                        wdata_q <= wdata_i;
                        be_q    <= be_i;
                        cnt_q   <= CntLoad;
                        if (!we_i) begin
                            // Reads always fetch both halves with both lanes on
                            state_q   <= StRdLo;
                            half_q    <= 1'b0;
                            sram_addr <= SRAM_AW'({addr_i[20:2], 1'b0});
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                            sram_ub_n <= 1'b0;
                            sram_lb_n <= 1'b0;
                        end else if (be_i == 4'b0000) begin
                            state_q  <= StDone;
                            rvalid_o <= 1'b1;
`ifdef RV_SRAM_SKIP_HALF_EN
                        end else if (be_i[1:0] == 2'b00) begin
                            state_q     <= StWrSetup;
                            half_q      <= 1'b1;
                            sram_addr   <= SRAM_AW'({addr_i[20:2], 1'b1});
                            sram_data_o <= wdata_i[31:16];
                            sram_ce_n   <= 1'b0;
                            sram_ub_n   <= ~be_i[3];
                            sram_lb_n   <= ~be_i[2];
`endif
                        end else begin
                            state_q     <= StWrSetup;
                            half_q      <= 1'b0;
                            sram_addr   <= SRAM_AW'({addr_i[20:2], 1'b0});
                            sram_data_o <= wdata_i[15:0];
                            sram_ce_n   <= 1'b0;
                            sram_ub_n   <= ~be_i[1];
                            sram_lb_n   <= ~be_i[0];
                        end
                    end
                end
                StRdLo: begin
                    if (cnt_q == '0) begin
                        rd_lo_q   <= sram_data_i;
                        state_q   <= StRdHi;
                        half_q    <= 1'b1;
                        sram_addr <= SRAM_AW'({idx_q, 1'b1});
                        cnt_q     <= CntLoad;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StRdHi: begin
                    if (cnt_q == '0) begin
                        rdata_o   <= {sram_data_i, rd_lo_q};
                        state_q   <= StDone;
                        rvalid_o  <= 1'b1;
                        cnt_q     <= CntLoad;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StWrSetup: begin
                    state_q   <= StWrPulse;
                    cnt_q     <= CntLoad;
                    sram_we_n <= 1'b0;
                end
                StWrPulse: begin
                    if (cnt_q == '0) begin
                        state_q   <= StWrHold;
                        cnt_q     <= CntLoad;
                        sram_we_n <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                StWrHold: begin
                    cnt_q <= CntLoad;
                    if (!half_q && hi_run) begin
                        state_q     <= StWrSetup;
                        half_q      <= 1'b1;
                        sram_addr   <= SRAM_AW'({idx_q, 1'b1});
                        sram_data_o <= wdata_q[31:16];
                        sram_ub_n   <= ~be_q[3];
                        sram_lb_n   <= ~be_q[2];
                    end else begin
                        state_q   <= StDone;
                        rvalid_o  <= 1'b1;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                    end
                end
                StDone: begin
                    state_q  <= StIdle;
                    rvalid_o <= 1'b0;
                    cnt_q    <= CntLoad;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv_sram_ctrl.sv
// Directed self-checking bench for rv_sram_ctrl with a behavioural SRAM model.
module tb_rv_sram_ctrl;

    localparam int unsigned W = 2;
`ifdef RV_SRAM_SKIP_HALF_EN
    localparam int LatByteLo = W + 3;
`else
    localparam int LatByteLo = 2 * (W + 2) + 1;
`endif

    logic        clk = 1'b0;
    logic        arstn_i;
    logic        req_i;
    logic        ready_o;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [3:0]  be_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [19:0] sram_addr;
    logic [15:0] sram_data_i;
    logic [15:0] sram_data_o;
    logic        sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] mem [1024];
    logic [19:0] pw_addr;
    logic [15:0] pw_data;
    int          ce_low_cnt = 0;
    logic        lo_ub, lo_lb;

    always #5 clk = ~clk;

    rv_sram_ctrl #(
        .WAIT_CYCLES (W),
        .SRAM_AW     (20)
    ) u_dut (
        .clk         (clk),
        .arstn_i     (arstn_i),
        .req_i       (req_i),
        .ready_o     (ready_o),
        .we_i        (we_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .be_i        (be_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .sram_addr   (sram_addr),
        .sram_data_i (sram_data_i),
        .sram_data_o (sram_data_o),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_ub_n   (sram_ub_n),
        .sram_lb_n   (sram_lb_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Asynchronous SRAM: read while ce/oe low, byte-lane write on rising we_n
    assign sram_data_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;

    always @(posedge sram_we_n) begin
        if (arstn_i && !sram_ce_n) begin
            if (!sram_lb_n) mem[sram_addr[9:0]][7:0]  = sram_data_o[7:0];
            if (!sram_ub_n) mem[sram_addr[9:0]][15:8] = sram_data_o[15:8];
        end
    end

    // Protocol monitors
    always @(negedge sram_we_n) begin
        pw_addr = sram_addr;
        pw_data = sram_data_o;
    end

    always @(negedge clk) begin
        check("oe_we_exclusive", {31'd0, !sram_oe_n && !sram_we_n}, 32'd0);
        if (!sram_we_n) begin
            check("addr_stable", {12'd0, sram_addr}, {12'd0, pw_addr});
            check("wdata_stable", {16'd0, sram_data_o}, {16'd0, pw_data});
            if (sram_addr[0] == 1'b0) begin
                lo_ub = sram_ub_n;
                lo_lb = sram_lb_n;
            end
        end
        if (!sram_ce_n) ce_low_cnt++;
    end

    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output int lat, output logic [31:0] rd);
        int guard;
        guard = 0;
        while (!ready_o && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req_i   = 1'b1;
        we_i    = we;
        addr_i  = addr;
        wdata_i = wdata;
        be_i    = be;
        @(posedge clk); #1;
        req_i = 1'b0;
        lat   = 1;
        while (!rvalid_o && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rdata_o;
        @(posedge clk); #1;
        check("rvalid_one_cycle", {31'd0, rvalid_o}, 32'd0);
    endtask

    int          lat;
    logic [31:0] rd;
    int          acc, np, guard;
    int          t [3];
    logic        rv_seen;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[6]  = 16'h3344;
        mem[7]  = 16'h1122;
        arstn_i = 1'b0;
        req_i   = 1'b0;
        we_i    = 1'b0;
        addr_i  = '0;
        wdata_i = '0;
        be_i    = '0;
        #12;
        check("rst_strobes", {27'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n},
              32'h1f);
        check("rst_addr", {12'd0, sram_addr}, 32'd0);
        check("rst_wdata", {16'd0, sram_data_o}, 32'd0);
        check("rst_rvalid", {31'd0, rvalid_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        @(negedge clk);
        arstn_i = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", {31'd0, ready_o}, 32'd1);

        // Reset in the middle of a write pulse
        req_i = 1'b1; we_i = 1'b1; addr_i = 32'h20; wdata_i = 32'h1234_5678; be_i = 4'hF;
        @(posedge clk); #1;
        req_i = 1'b0;
        check("busy_not_ready", {31'd0, ready_o}, 32'd0);
        guard = 0;
        while (sram_we_n && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("mid_we_low", {31'd0, sram_we_n}, 32'd0);
        #2 arstn_i = 1'b0;
        #1;
        check("async_rst_we", {31'd0, sram_we_n}, 32'd1);
        check("async_rst_ce", {31'd0, sram_ce_n}, 32'd1);
        @(negedge clk);
        arstn_i = 1'b1;
        rv_seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            rv_seen |= rvalid_o;
        end
        check("post_rst_ready", {31'd0, ready_o}, 32'd1);
        check("post_rst_no_rvalid", {31'd0, rv_seen}, 32'd0);

        // Full word write then read back
        access(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, lat, rd);
        check("wr_latency", lat, 32'd9);
        check("mem_hw8", {16'd0, mem[8]}, 32'h0000_BEEF);
        check("mem_hw9", {16'd0, mem[9]}, 32'h0000_DEAD);
        access(1'b0, 32'h10, 32'h0, 4'h0, lat, rd);
        check("rd_latency", lat, 32'd5);
        check("rd_data", rd, 32'hDEAD_BEEF);

        // Single byte write into byte 1 of a preloaded word
        lo_ub = 1'b1;
        lo_lb = 1'b1;
        access(1'b1, 32'h0C, 32'h0000_AB00, 4'b0010, lat, rd);
        check("byte_wr_latency", lat, LatByteLo);
        check("byte_lo_ub_n", {31'd0, lo_ub}, 32'd0);
        check("byte_lo_lb_n", {31'd0, lo_lb}, 32'd1);
        check("rdata_held", rdata_o, 32'hDEAD_BEEF);
        access(1'b0, 32'h0C, 32'h0, 4'hF, lat, rd);
        check("byte_readback", rd, 32'h1122_AB44);

        // Write with no byte enables: no SRAM activity, immediate completion
        ce_low_cnt = 0;
        access(1'b1, 32'h10, 32'h5555_5555, 4'h0, lat, rd);
        check("be0_latency", lat, 32'd1);
        check("be0_no_ce", ce_low_cnt, 32'd0);
        check("be0_mem_intact", {mem[9], mem[8]}, 32'hDEAD_BEEF);

        // Three back-to-back reads with req_i held high
        acc = 0;
        np  = 0;
        req_i = 1'b1; we_i = 1'b0; addr_i = 32'h10; be_i = 4'h0;
        for (int c = 0; c < 40; c++) begin
            if (req_i && ready_o) acc++;
            @(posedge clk); #1;
            if (acc == 3) req_i = 1'b0;
            if (rvalid_o) begin
                if (np < 3) t[np] = c;
                np++;
            end
        end
        check("b2b_pulses", np, 32'd3);
        check("b2b_gap0", t[1] - t[0], 32'd6);
        check("b2b_gap1", t[2] - t[1], 32'd6);
        check("b2b_data", rdata_o, 32'hDEAD_BEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
